// File: rtl/gpu_wb_write_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module   : gpu_wb_write_scheduler_if
//  Purpose  : Wishbone classic bus bundle between a host master and the GPU
//             write scheduler slave.
//  Signals  : wb_cyc_i   cycle valid            (master -> slave)
//             wb_stb_i   strobe                 (master -> slave)
//             wb_we_i    1=write, 0=read        (master -> slave)
//             wb_sel_i   byte selects [3:0]     (master -> slave)
//             wb_adr_i   byte address [26:0]    (master -> slave)
//             wb_dat_i   write data   [31:0]    (master -> slave)
//             wb_dat_o   read data    [31:0]    (slave  -> master)
//             wb_ack_o   acknowledge            (slave  -> master)
//  Revision : 1.0  initial release
// ============================================================================
interface gpu_wb_write_scheduler_if;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [3:0]  wb_sel_i;
    logic [26:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
        output wb_dat_o, wb_ack_o
    );
endinterface
`default_nettype wire

// File: rtl/gpu_wb_write_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : gpu_wb_write_scheduler
//  Purpose  : Wishbone slave front end for the GPU. Host writes are decoded
//             into CR / spirit / tile / texture regions, posted into an
//             in-order FIFO (host is acked immediately) and drained to the
//             target memories as one-cycle write strobes. Spirit, tile and
//             texture writes wait while the renderer owns those memories;
//             CR writes are never held by the renderer. GAP_CYCLES idle
//             cycles separate consecutive memory writes.
//  Options  : GPU_WB_READBACK_EN - CR-region reads return a status word
//             {16'h0, fifo_level, 5'h0, render_busy, full, empty};
//             otherwise wb_dat_o is tied to zero.
//  Params   : FIFO_DEPTH  posted-write entries (power of 2, >= 2)
//             GAP_CYCLES  idle cycles after each strobe (0..15)
//  Ports    : clk_100MHz     system clock, rising edge
//             wb_rst_i       asynchronous active-high reset
//             wb             Wishbone slave bundle
//             i_render_busy  renderer owns spirit/tile/texture memories
//             o_cr_we        CR write strobe
//             o_spirit_we    spirit-memory write strobe
//             o_tile_we      tile-map write strobe
//             o_texture_we   texture-memory write strobe
//             o_waddr        address of the issued write
//             o_wdata        data of the issued write
//             o_wsel         byte selects of the issued write
//             o_fifo_level   entries currently held
//             o_busy         FIFO non-empty or scheduler not idle
//  Revision : 1.0  initial release
// ============================================================================
module gpu_wb_write_scheduler #(
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic                          clk_100MHz,
    input  logic                          wb_rst_i,
    gpu_wb_write_scheduler_if.slave       wb,
    input  logic                          i_render_busy,
    output logic                          o_cr_we,
    output logic                          o_spirit_we,
    output logic                          o_tile_we,
    output logic                          o_texture_we,
    output logic [26:0]                   o_waddr,
    output logic [31:0]                   o_wdata,
    output logic [3:0]                    o_wsel,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
    output logic                          o_busy
);

    localparam int                 c_PTR_W      = $clog2(FIFO_DEPTH);
    localparam logic [c_PTR_W:0]   c_CNT_ONE    = (c_PTR_W + 1)'(1);
    localparam logic [c_PTR_W:0]   c_CNT_FULL   = (c_PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [3:0]         c_GAP_LAST   = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    localparam logic [1:0]         c_REG_CR      = 2'd0;
    localparam logic [1:0]         c_REG_SPIRIT  = 2'd1;
    localparam logic [1:0]         c_REG_TILE    = 2'd2;
    localparam logic [1:0]         c_REG_TEXTURE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Bus request / acknowledge
    // ------------------------------------------------------------------
    logic               r_ack;
    logic [c_PTR_W:0]   r_count;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;

    logic               w_req;
    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic [1:0]         w_push_region;

    // The ~r_ack term keeps a master that still holds stb in the ack cycle
    // from being counted twice.
    assign w_req  = wb.wb_cyc_i & wb.wb_stb_i & ~r_ack;
    // Fullness is judged on the registered count, so a pop in this cycle
    // only makes room from the next cycle on.
    assign w_full = (r_count == c_CNT_FULL);
    assign w_push = w_req & wb.wb_we_i & ~w_full;

    always_comb begin
        w_push_region = c_REG_TEXTURE;
        if (wb.wb_adr_i[15:12] == 4'h0) begin
            if (wb.wb_adr_i[11:8] == 4'h0) begin
                w_push_region = c_REG_CR;
            end else begin
                w_push_region = c_REG_SPIRIT;
            end
        end else if (wb.wb_adr_i[15:12] == 4'h1) begin
            w_push_region = c_REG_TILE;
        end
    end

    always_ff @(posedge clk_100MHz or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_ack <= 1'b0;
        end else begin
            // Reads are always acked; writes only when there is room.
            r_ack <= w_req & (~wb.wb_we_i | ~w_full);
        end
    end

    assign wb.wb_ack_o = r_ack;

`ifdef GPU_WB_READBACK_EN
    logic [31:0] r_dat;
    logic [31:0] w_status;
    logic        w_rd_cr;

    assign w_status = {16'h0000, 8'(r_count), 5'h00, i_render_busy, w_full, (r_count == '0)};
    assign w_rd_cr  = w_req & ~wb.wb_we_i & (wb.wb_adr_i[15:8] == 8'h00);

    always_ff @(posedge clk_100MHz or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_dat <= 32'h0;
        end else begin
            r_dat <= w_rd_cr ? w_status : 32'h0;
        end
    end

    assign wb.wb_dat_o = r_dat;
`else
    assign wb.wb_dat_o = 32'h0;
`endif

    // ------------------------------------------------------------------
    // Posted-write FIFO. Storage carries no reset: pointers and count
    // define validity, so stale contents are never observed.
    // ------------------------------------------------------------------
    logic [1:0]  r_mem_region [FIFO_DEPTH];
    logic [26:0] r_mem_adr    [FIFO_DEPTH];
    logic [31:0] r_mem_dat    [FIFO_DEPTH];
    logic [3:0]  r_mem_sel    [FIFO_DEPTH];

    always_ff @(posedge clk_100MHz) begin
        if (w_push) begin
            r_mem_region[r_wr_ptr] <= w_push_region;
            r_mem_adr[r_wr_ptr]    <= wb.wb_adr_i;
            r_mem_dat[r_wr_ptr]    <= wb.wb_dat_i;
            r_mem_sel[r_wr_ptr]    <= wb.wb_sel_i;
        end
    end

    always_ff @(posedge clk_100MHz or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Drain scheduler
    // ------------------------------------------------------------------
    state_t             r_state;
    state_t             w_state_nxt;
    logic [3:0]         r_gap_cnt;
    logic               w_issue;
    logic [c_PTR_W-1:0] w_head_ptr;
    logic               w_head_avail;
    logic               w_head_ready;
    logic [1:0]         w_head_region;

    // The entry being popped in ISSUE is still counted, so the candidate
    // for a back-to-back issue is the one behind it.
    assign w_pop         = (r_state == ST_ISSUE);
    assign w_head_ptr    = w_pop ? (r_rd_ptr + 1'b1) : r_rd_ptr;
    assign w_head_avail  = w_pop ? (r_count > c_CNT_ONE) : (r_count != '0);
    assign w_head_region = r_mem_region[w_head_ptr];
    // Strict in-order: a blocked head stalls everything behind it.
    assign w_head_ready  = w_head_avail & ~((w_head_region != c_REG_CR) & i_render_busy);

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_head_ready) begin
                    w_state_nxt = ST_ISSUE;
                    w_issue     = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (GAP_CYCLES > 0) begin
                    w_state_nxt = ST_GAP;
                end else if (w_head_ready) begin
                    w_state_nxt = ST_ISSUE;
                    w_issue     = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_GAP: begin
                // The last gap cycle makes the idle decision itself so the
                // strobe spacing is exactly GAP_CYCLES idle cycles.
                if (r_gap_cnt == c_GAP_LAST) begin
                    if (w_head_ready) begin
                        w_state_nxt = ST_ISSUE;
                        w_issue     = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Strobes and write fields are loaded on the edge that enters ISSUE,
    // so they are registered and high exactly while the FSM is in ISSUE.
    always_ff @(posedge clk_100MHz or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state      <= ST_IDLE;
            r_gap_cnt    <= 4'd0;
            o_cr_we      <= 1'b0;
            o_spirit_we  <= 1'b0;
            o_tile_we    <= 1'b0;
            o_texture_we <= 1'b0;
            o_waddr      <= 27'h0;
            o_wdata      <= 32'h0;
            o_wsel       <= 4'h0;
        end else begin
            r_state      <= w_state_nxt;
            r_gap_cnt    <= (r_state == ST_GAP) ? (r_gap_cnt + 4'd1) : 4'd0;
            o_cr_we      <= w_issue & (w_head_region == c_REG_CR);
            o_spirit_we  <= w_issue & (w_head_region == c_REG_SPIRIT);
            o_tile_we    <= w_issue & (w_head_region == c_REG_TILE);
            o_texture_we <= w_issue & (w_head_region == c_REG_TEXTURE);
            if (w_issue) begin
                o_waddr <= r_mem_adr[w_head_ptr];
                o_wdata <= r_mem_dat[w_head_ptr];
                o_wsel  <= r_mem_sel[w_head_ptr];
            end
        end
    end

    assign o_fifo_level = r_count;
    assign o_busy       = (r_count != '0) | (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_gpu_wb_write_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gpu_wb_write_scheduler
//  Purpose  : Directed self-checking bench for gpu_wb_write_scheduler
//             (FIFO_DEPTH=4, GAP_CYCLES=1). Cycle k is the interval after
//             the k-th rising edge; inputs change and outputs are sampled
//             1 ns after the edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_gpu_wb_write_scheduler;

    logic        clk_100MHz = 1'b0;
    logic        wb_rst_i   = 1'b1;
    logic        i_render_busy = 1'b0;
    logic        o_cr_we, o_spirit_we, o_tile_we, o_texture_we;
    logic [26:0] o_waddr;
    logic [31:0] o_wdata;
    logic [3:0]  o_wsel;
    logic [2:0]  o_fifo_level;
    logic        o_busy;
    logic [3:0]  strb;

    int n_checks = 0;
    int n_errors = 0;

    gpu_wb_write_scheduler_if bus ();

    gpu_wb_write_scheduler #(
        .FIFO_DEPTH (4),
        .GAP_CYCLES (1)
    ) dut (
        .clk_100MHz    (clk_100MHz),
        .wb_rst_i      (wb_rst_i),
        .wb            (bus),
        .i_render_busy (i_render_busy),
        .o_cr_we       (o_cr_we),
        .o_spirit_we   (o_spirit_we),
        .o_tile_we     (o_tile_we),
        .o_texture_we  (o_texture_we),
        .o_waddr       (o_waddr),
        .o_wdata       (o_wdata),
        .o_wsel        (o_wsel),
        .o_fifo_level  (o_fifo_level),
        .o_busy        (o_busy)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    // {cr, spirit, tile, texture}
    assign strb = {o_cr_we, o_spirit_we, o_tile_we, o_texture_we};

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_100MHz);
        #1;
    endtask

    task automatic bus_idle();
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
    endtask

    task automatic drive_wr(input logic [26:0] adr, input logic [31:0] dat);
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = 1'b1;
        bus.wb_adr_i = adr;
        bus.wb_dat_i = dat;
        bus.wb_sel_i = 4'hF;
    endtask

    // Complete one write, waiting for ack within a bounded number of cycles.
    task automatic wb_write(input logic [26:0] adr, input logic [31:0] dat);
        int n;
        n = 0;
        drive_wr(adr, dat);
        tick();
        while (!bus.wb_ack_o && n < 50) begin
            tick();
            n++;
        end
        check($sformatf("wr_ack_%0h", adr), 64'(bus.wb_ack_o), 64'd1);
        bus_idle();
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        bus_idle();
        bus.wb_sel_i = 4'h0;
        bus.wb_adr_i = 27'h0;
        bus.wb_dat_i = 32'h0;

        // ---------------- reset state ----------------
        tick(); tick(); tick();
        check("rst_strb",  64'(strb),         64'h0);
        check("rst_level", 64'(o_fifo_level), 64'h0);
        check("rst_busy",  64'(o_busy),       64'h0);
        check("rst_ack",   64'(bus.wb_ack_o), 64'h0);
        check("rst_waddr", 64'(o_waddr),      64'h0);
        check("rst_dat_o", 64'(bus.wb_dat_o), 64'h0);
        wb_rst_i = 1'b0;
        tick();

        // ---------------- single CR write ----------------
        drive_wr(27'h0000004, 32'h0000001F);            // cycle N
        check("cr_ack_N", 64'(bus.wb_ack_o), 64'h0);
        tick();                                          // N+1
        check("cr_ack_N1",   64'(bus.wb_ack_o), 64'h1);
        check("cr_strb_N1",  64'(strb),         64'h0);
        check("cr_level_N1", 64'(o_fifo_level), 64'h1);
        bus_idle();
        tick();                                          // N+2
        check("cr_strb_N2", 64'(strb),         64'h8);
        check("cr_waddr",   64'(o_waddr),      64'h4);
        check("cr_wdata",   64'(o_wdata),      64'h1F);
        check("cr_wsel",    64'(o_wsel),       64'hF);
        check("cr_ack_N2",  64'(bus.wb_ack_o), 64'h0);
        tick();                                          // N+3 (gap)
        check("cr_strb_N3", 64'(strb),   64'h0);
        check("cr_busy_N3", 64'(o_busy), 64'h1);
        check("cr_wdata_hold", 64'(o_wdata), 64'h1F);
        tick();
        check("cr_busy_N4", 64'(o_busy), 64'h0);

        // ---------------- texture write held by renderer ----------------
        i_render_busy = 1'b1;
        wb_write(27'h0002000, 32'hA5A5A5A5);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (strb != 4'h0) seen++;
            tick();
        end
        check("tex_held", 64'(seen), 64'h0);
        check("tex_level_held", 64'(o_fifo_level), 64'h1);
        i_render_busy = 1'b0;                            // cycle M
        check("tex_strb_M", 64'(strb), 64'h0);
        tick();                                          // M+1
        check("tex_strb_M1", 64'(strb),    64'h1);
        check("tex_waddr",   64'(o_waddr), 64'h2000);
        check("tex_wdata",   64'(o_wdata), 64'hA5A5A5A5);
        tick();
        check("tex_strb_M2", 64'(strb), 64'h0);
        tick(); tick();

        // ---------------- fill FIFO, stall 5th, ordered drain ----------------
        i_render_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wb_write(27'h0001000 + 27'(4 * i), 32'h100 + 32'(i));
        end
        check("fill_level", 64'(o_fifo_level), 64'h4);
        drive_wr(27'h0001010, 32'h104);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.wb_ack_o) seen++;
        end
        check("full_no_ack", 64'(seen), 64'h0);
        check("full_level",  64'(o_fifo_level), 64'h4);
        i_render_busy = 1'b0;                            // cycle M
        for (int k = 1; k <= 10; k++) begin
            tick();                                      // M+k
            check($sformatf("drain_strb_%0d", k), 64'(strb),
                  ((k % 2) == 1 && k <= 9) ? 64'h2 : 64'h0);
            if ((k % 2) == 1 && k <= 9) begin
                check($sformatf("drain_addr_%0d", k), 64'(o_waddr),
                      64'h1000 + 64'(4 * ((k - 1) / 2)));
                check($sformatf("drain_data_%0d", k), 64'(o_wdata),
                      64'h100 + 64'((k - 1) / 2));
            end
            if (k == 2) check("fifth_ack_M2", 64'(bus.wb_ack_o), 64'h0);
            if (k == 3) begin
                check("fifth_ack_M3", 64'(bus.wb_ack_o), 64'h1);
                bus_idle();
            end
        end
        check("drain_level", 64'(o_fifo_level), 64'h0);
        tick();
        check("drain_idle", 64'(o_busy), 64'h0);

        // ---------------- blocked tile head also blocks CR ----------------
        i_render_busy = 1'b1;
        wb_write(27'h0001020, 32'hCAFE0001);
        wb_write(27'h0000008, 32'hCAFE0002);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (strb != 4'h0) seen++;
            tick();
        end
        check("order_held", 64'(seen), 64'h0);
        i_render_busy = 1'b0;                            // M
        tick();                                          // M+1
        check("order_tile", 64'(strb), 64'h2);
        tick();                                          // M+2
        check("order_gap",  64'(strb), 64'h0);
        tick();                                          // M+3
        check("order_cr",   64'(strb), 64'h8);
        check("order_cr_d", 64'(o_wdata), 64'hCAFE0002);
        tick(); tick();

        // ---------------- reset mid-drain ----------------
        i_render_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wb_write(27'h0001100 + 27'(4 * i), 32'h200 + 32'(i));
        end
        i_render_busy = 1'b0;
        tick();
        check("rstmid_first", 64'(strb), 64'h2);
        wb_rst_i = 1'b1;
        #1;
        check("rstmid_strb",  64'(strb),         64'h0);
        check("rstmid_level", 64'(o_fifo_level), 64'h0);
        tick();
        wb_rst_i = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (strb != 4'h0) seen++;
        end
        check("rstmid_none", 64'(seen),   64'h0);
        check("rstmid_busy", 64'(o_busy), 64'h0);

        // ---------------- status readback ----------------
        i_render_busy = 1'b1;
        wb_write(27'h0001200, 32'h300);
        wb_write(27'h0001204, 32'h301);
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = 1'b0;
        bus.wb_adr_i = 27'h0;
        tick();
        check("rd_ack", 64'(bus.wb_ack_o), 64'h1);
`ifdef GPU_WB_READBACK_EN
        check("rd_status", 64'(bus.wb_dat_o), 64'h00000204);
`else
        check("rd_status", 64'(bus.wb_dat_o), 64'h00000000);
`endif
        bus_idle();
        tick();
        check("rd_ack_once", 64'(bus.wb_ack_o), 64'h0);
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_adr_i = 27'h0001000;
        tick();
        check("rd_tile_ack", 64'(bus.wb_ack_o), 64'h1);
        check("rd_tile_dat", 64'(bus.wb_dat_o), 64'h0);
        bus_idle();
        check("rd_no_push", 64'(o_fifo_level), 64'h2);
        i_render_busy = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("rd_drained", 64'(o_fifo_level), 64'h0);
        check("rd_last",    64'(o_wdata),      64'h301);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
